// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and default widths for the memory write arbiter.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
//
// Contents: FSM state enum, round-robin pointer encodings, default widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHARED = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Round-robin pointer: which requester gets first claim on the next grant.
  localparam logic PTR_CPU  = 1'b0;
  localparam logic PTR_HOST = 1'b1;

endpackage

// File: rtl/arb_grant.sv
// Purpose : grant selection between CPU and host write requesters.
// Latency : combinational.
// Backpr. : at most one ready high; IDLE grants nobody, LOCKED grants host only.
//
// Ports:
//   i_cpu_valid, i_host_valid : request valids
//   i_ptr                     : round-robin pointer (PTR_CPU / PTR_HOST)
//   i_state                   : current arbiter FSM state
//   o_cpu_ready, o_host_ready : grants
// Build option: define ARB_ROUND_ROBIN_EN for round-robin sharing; otherwise
// host has fixed priority over CPU.
module arb_grant
  import mem_arb_pkg::*;
(
  input  logic       i_cpu_valid,
  input  logic       i_host_valid,
  input  logic       i_ptr,
  input  logic [1:0] i_state,
  output logic       o_cpu_ready,
  output logic       o_host_ready
);

  arb_state_t w_state;
  assign w_state = arb_state_t'(i_state);

`ifndef ARB_ROUND_ROBIN_EN
  // Pointer only matters for round-robin sharing.
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;
`endif

  always_comb begin
    o_cpu_ready  = 1'b0;
    o_host_ready = 1'b0;
    case (w_state)
      LOCKED: o_host_ready = 1'b1;
      SHARED: begin
`ifdef ARB_ROUND_ROBIN_EN
        // Pointed requester wins if it is asking; otherwise the other side
        // is offered the slot.
        if (i_ptr == PTR_CPU) begin
          o_cpu_ready  = i_cpu_valid;
          o_host_ready = !i_cpu_valid;
        end else begin
          o_host_ready = i_host_valid;
          o_cpu_ready  = !i_host_valid;
        end
`else
        o_host_ready = i_host_valid;
        o_cpu_ready  = !i_host_valid;
`endif
      end
      default: begin
        o_cpu_ready  = 1'b0;
        o_host_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// Purpose : arbitrates CPU and host-loader writes onto one memory write port.
// Latency : accepted write appears on mem_we/mem_a/mem_d one cycle later.
// Backpr. : valid/ready per requester; loser stalls holding its payload.
//
// Ports:
//   clk, rst                           : clock, synchronous active-high reset
//   cpu_valid/addr/data, cpu_ready     : CPU write channel
//   host_valid/addr/data, host_ready   : host loader write channel
//   host_lock                          : host claims exclusive write ownership
//   mem_we, mem_a, mem_d               : registered memory write port
//   cpu_rd_addr, rd_hazard             : CPU read address, write-collision flag
//   host_wr_cnt                        : wrapping count of accepted host writes
// Build option: ARB_ROUND_ROBIN_EN selects round-robin sharing (default:
// fixed host-over-CPU priority).
module mem_write_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ready,
  input  logic              host_valid,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic              host_lock,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [ADDR_W-1:0] cpu_rd_addr,
  output logic              rd_hazard,
  output logic [CNT_W-1:0]  host_wr_cnt
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_rr_ptr;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_a;
  logic [DATA_W-1:0] r_mem_d;
  logic [CNT_W-1:0]  r_host_wr_cnt;

  logic w_cpu_ready;
  logic w_host_ready;
  logic w_cpu_xfer;
  logic w_host_xfer;

  arb_grant u_grant (
    .i_cpu_valid  (cpu_valid),
    .i_host_valid (host_valid),
    .i_ptr        (r_rr_ptr),
    .i_state      (r_state),
    .o_cpu_ready  (w_cpu_ready),
    .o_host_ready (w_host_ready)
  );

  assign w_cpu_xfer  = cpu_valid  && w_cpu_ready;
  assign w_host_xfer = host_valid && w_host_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state. A transfer granted in the cycle host_lock rises still
  // completes under SHARED rules; the lock takes effect next cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = SHARED;
      SHARED:  if (host_lock)  w_state_nxt = LOCKED;
      LOCKED:  if (!host_lock) w_state_nxt = SHARED;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write register, round-robin pointer and host write counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= PTR_CPU;
      r_mem_we      <= 1'b0;
      r_mem_a       <= '0;
      r_mem_d       <= '0;
      r_host_wr_cnt <= '0;
    end else begin
      r_mem_we <= w_cpu_xfer || w_host_xfer;
      if (w_cpu_xfer) begin
        r_mem_a  <= cpu_addr;
        r_mem_d  <= cpu_data;
        r_rr_ptr <= PTR_HOST;
      end else if (w_host_xfer) begin
        r_mem_a       <= host_addr;
        r_mem_d       <= host_data;
        r_rr_ptr      <= PTR_CPU;
        r_host_wr_cnt <= r_host_wr_cnt + 1'b1;
      end
    end
  end

  assign cpu_ready  = w_cpu_ready;
  assign host_ready = w_host_ready;

  // A reset arriving while a write sits in the output register cancels it
  // immediately so memory never sees a write from before the reset.
  assign mem_we      = r_mem_we && !rst;
  assign mem_a       = r_mem_a;
  assign mem_d       = r_mem_d;
  assign rd_hazard   = mem_we && (r_mem_a == cpu_rd_addr);
  assign host_wr_cnt = r_host_wr_cnt;

endmodule

// File: tb/tb_mem_write_arbiter.sv
module tb_mem_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid, host_valid, host_lock;
  logic [7:0]  cpu_addr, host_addr, cpu_rd_addr;
  logic [31:0] cpu_data, host_data;
  logic        cpu_ready, host_ready;
  logic        mem_we, rd_hazard;
  logic [7:0]  mem_a;
  logic [31:0] mem_d;
  logic [15:0] host_wr_cnt;

  mem_write_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .host_lock(host_lock),
    .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
    .cpu_rd_addr(cpu_rd_addr), .rd_hazard(rd_hazard), .host_wr_cnt(host_wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  typedef struct { int stamp; logic [7:0] a; logic [31:0] d; } exp_t;

  wr_t  cpu_q[$];
  wr_t  host_q[$];
  exp_t sb[$];
  logic [7:0] dut_log[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hz_cnt = 0;
  int cpu_rate = 100;
  int host_rate = 100;
  logic s_cpu_rdy;
  logic last_xc = 1'b0, last_xh = 1'b0;

  // Reference model: abstract arbiter status
  bit          m_fresh = 1'b1;   // first cycle after reset: nobody granted
  bit          m_locked = 1'b0;  // host owns the port
  bit          m_turn_host = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void model_grant(output logic gc, output logic gh);
    gc = 1'b0;
    gh = 1'b0;
    if (m_fresh) begin
      gc = 1'b0;
    end else if (m_locked) begin
      gh = 1'b1;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (!m_turn_host) begin
        if (cpu_valid) gc = 1'b1; else gh = 1'b1;
      end else begin
        if (host_valid) gh = 1'b1; else gc = 1'b1;
      end
`else
      if (host_valid) gh = 1'b1; else gc = 1'b1;
`endif
    end
  endfunction

  task automatic drive();
    if (last_xc || cpu_q.size() == 0) cpu_valid = 1'b0;
    if (!cpu_valid && cpu_q.size() > 0) cpu_valid = ($urandom_range(0, 99) < cpu_rate);
    if (cpu_valid) begin
      cpu_addr = cpu_q[0].a; cpu_data = cpu_q[0].d;
    end else begin
      cpu_addr = 8'($urandom); cpu_data = $urandom;
    end
    if (last_xh || host_q.size() == 0) host_valid = 1'b0;
    if (!host_valid && host_q.size() > 0) host_valid = ($urandom_range(0, 99) < host_rate);
    if (host_valid) begin
      host_addr = host_q[0].a; host_data = host_q[0].d;
    end else begin
      host_addr = 8'($urandom); host_data = $urandom;
    end
  endtask

  // One clock: check grants at negedge, predict transfers, advance model.
  task automatic step();
    logic gc, gh, lock_s, rst_s;
    @(negedge clk);
    model_grant(gc, gh);
    s_cpu_rdy = cpu_ready;
    if (!rst) begin
      chk("cpu_ready", 32'(cpu_ready), 32'(gc));
      chk("host_ready", 32'(host_ready), 32'(gh));
      chk("host_wr_cnt", 32'(host_wr_cnt), 32'(m_cnt));
    end
    last_xc = !rst && cpu_valid && gc && cpu_q.size() > 0;
    last_xh = !rst && host_valid && gh && host_q.size() > 0;
    if (last_xc) begin
      sb.push_back('{stamp: cyc + 1, a: cpu_q[0].a, d: cpu_q[0].d});
      cpu_q.delete(0);
    end
    if (last_xh) begin
      sb.push_back('{stamp: cyc + 1, a: host_q[0].a, d: host_q[0].d});
      host_q.delete(0);
    end
    lock_s = host_lock;
    rst_s  = rst;
    @(posedge clk);
    cyc++;
    if (rst_s) begin
      m_fresh = 1'b1; m_locked = 1'b0; m_turn_host = 1'b0; m_cnt = 16'd0;
    end else begin
      m_locked = m_fresh ? 1'b0 : lock_s;
      m_fresh  = 1'b0;
      if (last_xc) m_turn_host = 1'b1;
      else if (last_xh) m_turn_host = 1'b0;
      if (last_xh) m_cnt = m_cnt + 16'd1;
    end
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((cpu_q.size() > 0 || host_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout @cyc %0d: %0d/%0d writes left", cyc, cpu_q.size(), host_q.size());
      cpu_q.delete(); host_q.delete();
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  // Monitor: compares the memory port against the scoreboard each cycle.
  initial begin
    exp_t e;
    logic       exp_we;
    logic [7:0] ea;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      exp_we = 1'b0; ea = 8'h0; ed = 32'h0;
      if (sb.size() > 0 && sb[0].stamp == cyc) begin
        e = sb.pop_front();
        exp_we = !rst;
        ea = e.a; ed = e.d;
      end
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
        chk("mem_a", 32'(mem_a), 32'(ea));
        chk("mem_d", mem_d, ed);
      end
      chk("rd_hazard", 32'(rd_hazard), 32'(exp_we && (ea == cpu_rd_addr)));
      if (mem_we) dut_log.push_back(mem_a);
      if (rd_hazard) hz_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_order[8];
    int seen, n0;
    rst = 1'b1; host_lock = 1'b0; cpu_rd_addr = 8'hFF;
    cpu_valid = 1'b0; host_valid = 1'b0;
    cpu_addr = 8'h0; cpu_data = 32'h0; host_addr = 8'h0; host_data = 32'h0;

    // Reset: two cycles, then an IDLE cycle with no grants, then SHARED.
    step(); step();
    rst = 1'b0;
    step();
    chk("cnt_after_reset", 32'(host_wr_cnt), 32'd0);
    step();

    // Single CPU write produces exactly one pulse.
    dut_log.delete();
    cpu_q.push_back('{a: 8'h10, d: 32'h3C013DCC});
    drain(20);
    chk("single_pulses", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() > 0) chk("single_addr", 32'(dut_log[0]), 32'h10);

    // Both requesters continuously valid, 4 writes each.
    do_reset();
    dut_log.delete();
    for (int i = 0; i < 4; i++) begin
      cpu_q.push_back('{a: 8'h20 + 8'(i), d: $urandom});
      host_q.push_back('{a: 8'h40 + 8'(i), d: $urandom});
    end
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_order[2*i]   = 8'h20 + 8'(i);
      exp_order[2*i+1] = 8'h40 + 8'(i);
`else
      exp_order[i]     = 8'h40 + 8'(i);
      exp_order[i+4]   = 8'h20 + 8'(i);
`endif
    end
    drain(40);
    chk("order_len", 32'(dut_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < dut_log.size(); i++) chk("order", 32'(dut_log[i]), 32'(exp_order[i]));

    // Locked burst: 256 host writes, CPU waiting throughout.
    do_reset();
    step();
    host_lock = 1'b1;
    step();
    for (int i = 0; i < 256; i++) host_q.push_back('{a: 8'(i), d: $urandom});
    cpu_q.push_back('{a: 8'hC5, d: 32'hA5A55A5A});
    seen = 0; n0 = 0;
    while (host_q.size() > 0 && n0 < 400) begin
      step();
      n0++;
      if (s_cpu_rdy === 1'b1) seen++;
    end
    chk("lock_cpu_ready_seen", 32'(seen), 32'd0);
    step();
    chk("lock_host_cnt", 32'(host_wr_cnt), 32'd256);
    dut_log.delete();
    host_lock = 1'b0;
    drain(20);
    chk("unlock_cpu_writes", 32'(dut_log.size()), 32'd1);
    if (dut_log.size() > 0) chk("unlock_cpu_addr", 32'(dut_log[dut_log.size()-1]), 32'hC5);

    // Read/write hazard flag.
    cpu_rd_addr = 8'h02;
    hz_cnt = 0;
    cpu_q.push_back('{a: 8'h02, d: $urandom});
    drain(20);
    chk("hazard_hit", 32'(hz_cnt), 32'd1);
    hz_cnt = 0;
    cpu_q.push_back('{a: 8'h03, d: $urandom});
    drain(20);
    chk("hazard_miss", 32'(hz_cnt), 32'd0);

    // Reset in the cycle after an accepted write discards it.
    host_q.push_back('{a: 8'h77, d: 32'hDEADBEEF});
    n0 = 0;
    while (host_q.size() > 0 && n0 < 20) begin step(); n0++; end
    dut_log.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_discard_pulses", 32'(dut_log.size()), 32'd0);
    chk("rst_discard_cnt", 32'(host_wr_cnt), 32'd0);
    step();

    // Randomized traffic with lock toggles and occasional reset.
    cpu_rate = 60; host_rate = 50;
    for (int i = 0; i < 500; i++) begin
      if (cpu_q.size() < 3 && $urandom_range(0, 2) == 0)
        cpu_q.push_back('{a: 8'($urandom_range(0, 7)), d: $urandom});
      if (host_q.size() < 3 && $urandom_range(0, 2) == 0)
        host_q.push_back('{a: 8'($urandom_range(0, 7)), d: $urandom});
      if ($urandom_range(0, 19) == 0) host_lock = !host_lock;
      rst = ($urandom_range(0, 149) == 0);
      cpu_rd_addr = 8'($urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    host_lock = 1'b0;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
